// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host-to-device transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, output tx_start, input busy, input done, input err);
  modport slave  (input tx_data, input tx_start, output busy, output done, output err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data bits LSB-first,
// odd parity and stop clocked by the device, then line-ACK check, guarded by a watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DATA
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    INHIBIT     = 3'd1,
    START       = 3'd2,
    BITS        = 3'd3,
    ACK_WAIT    = 3'd4,
    ACK_RELEASE = 3'd5
  } state_t;

  localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t      state_r, state_s;
  logic [20:0] cnt_r, cnt_s;
  logic [3:0]  bit_cnt_r, bit_cnt_s;
  logic [9:0]  shift_r, shift_s;
  logic        clk_low_r, clk_low_s;
  logic        data_low_r, data_low_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic [2:0]  clk_sync_r;   // [1] is the synchronized level, [2] its previous value
  logic [1:0]  data_sync_r;
  logic        clk_fall_s;

  assign PS2_CLK  = clk_low_r  ? 1'b0 : 1'bz;
  assign PS2_DATA = data_low_r ? 1'b0 : 1'bz;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;

  assign clk_fall_s = clk_sync_r[2] & ~clk_sync_r[1];

  // Bring the open-drain lines into the clk domain; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 3'b111;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], PS2_CLK};
      data_sync_r <= {data_sync_r[0], PS2_DATA};
    end
  end

  // Next-state, counter and line-drive decisions for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    clk_low_s  = clk_low_r;
    data_low_s = data_low_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        clk_low_s  = 1'b0;
        data_low_s = 1'b0;
        busy_s     = 1'b0;
        cnt_s      = 21'd0;
        bit_cnt_s  = 4'd0;
        if (bus.tx_start) begin
          shift_s   = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
          clk_low_s = 1'b1;
          busy_s    = 1'b1;
          state_s   = INHIBIT;
        end else begin
          state_s = IDLE;
        end
      end
      INHIBIT: begin
        if (cnt_r == INHIBIT_LAST) begin
          cnt_s      = 21'd0;
          clk_low_s  = 1'b0;
          data_low_s = 1'b1;
          state_s    = START;
        end else begin
          cnt_s = cnt_r + 21'd1;
        end
      end
      START, BITS, ACK_WAIT, ACK_RELEASE: begin
        cnt_s = clk_fall_s ? 21'd0 : cnt_r + 21'd1;
        if (!clk_fall_s && (cnt_r == TIMEOUT_LAST)) begin
          // Device stopped clocking: give the bus back and report failure.
          state_s    = IDLE;
          cnt_s      = 21'd0;
          bit_cnt_s  = 4'd0;
          clk_low_s  = 1'b0;
          data_low_s = 1'b0;
          busy_s     = 1'b0;
          err_s      = 1'b1;
        end else if (state_r == START) begin
          state_s = BITS;
        end else if (state_r == BITS) begin
          if (clk_fall_s) begin
            data_low_s = ~shift_r[0];
            shift_s    = {1'b0, shift_r[9:1]};
            bit_cnt_s  = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd9) begin
              state_s = ACK_WAIT;
            end else begin
              state_s = BITS;
            end
          end else begin
            state_s = BITS;
          end
        end else if (state_r == ACK_WAIT) begin
          if (clk_fall_s) begin
            if (data_sync_r[1]) begin
              state_s = IDLE;
              busy_s  = 1'b0;
              err_s   = 1'b1;
            end else begin
              state_s = ACK_RELEASE;
            end
          end else begin
            state_s = ACK_WAIT;
          end
        end else begin
          if (clk_sync_r[1] && data_sync_r[1]) begin
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = ACK_RELEASE;
          end
        end
      end
      default: begin
        state_s    = IDLE;
        clk_low_s  = 1'b0;
        data_low_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State, counters, frame shifter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 21'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'd0;
      clk_low_r  <= 1'b0;
      data_low_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      clk_low_r  <= clk_low_s;
      data_low_r <= data_low_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a modelled PS/2 device clocks frames out of the host and a
// scoreboard of expected frames/outcomes is checked against what the device samples.
module tb_ps2_host_tx;
  localparam int INHIBIT = 1200;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 15;

  typedef struct packed {
    logic [10:0] bits;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk;
  wire  ps2_data;

  ps2_host_tx_if bus ();

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_at_done = 0;
  int   inh_run = 0, last_inh = 0, start_cyc = 0, err_cyc = 0;
  logic prev_data = 1'b1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  always @(posedge clk) cyc++;

  // Pulse counters plus host-inhibit length and start-bit timestamp.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (bus.busy) busy_at_done++;
    end
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.done && bus.err) both_cnt++;
    if (ps2_clk === 1'b0 && !dev_clk_low) inh_run++;
    else if (inh_run != 0) begin
      last_inh = inh_run;
      inh_run  = 0;
    end
    if (ps2_data === 1'b0 && prev_data === 1'b1 && !dev_data_low) start_cyc = cyc;
    prev_data = ps2_data;
  end

  task automatic send(input logic [7:0] d, input bit track, input bit ok);
    exp_t e;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    if (track) begin
      e.bits = frame_of(d);
      e.ok   = ok;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.tx_start = 1'b0;
    chk_eq($sformatf("busy_after_start_%02h", d), bus.busy, 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < INHIBIT + 1000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk_eq("done_wait", seen, 1);
  endtask

  task automatic device_txn(input bit ack, input int n_edges);
    logic [10:0] got;
    exp_t        e;
    bit          seen;
    int          d0, e0;
    got  = 11'd0;
    seen = 1'b0;
    d0   = done_cnt;
    e0   = err_cnt;
    for (int i = 0; i < INHIBIT + 200; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b1 && ps2_data === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk_eq("start_seen", seen, 1);
    if (!seen) return;
    got[0] = ps2_data;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) got[k] = ps2_data;
      dev_clk_low = 1'b0;
    end
    if (n_edges < 11) return;
    chk_eq("inhibit_len", last_inh, INHIBIT);
    chk_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk_eq($sformatf("frame_%02h", e.bits[8:1]), got, e.bits);
    repeat (HALF) @(negedge clk);
    dev_data_low = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0 || err_cnt != e0) begin
        seen = 1'b1;
        break;
      end
    end
    chk_eq("outcome_seen", seen, 1);
    chk_eq("outcome_done", done_cnt - d0, e.ok);
    chk_eq("outcome_err", err_cnt - e0, !e.ok);
  endtask

  initial begin
    bit seen;
    int d0, e0;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_done", bus.done, 0);
    chk_eq("rst_err", bus.err, 0);
    chk_eq("rst_clk_pin", ps2_clk, 1);
    chk_eq("rst_data_pin", ps2_data, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED with ACK; 0xFF requested in the very cycle done pulses.
    fork
      send(8'hED, 1'b1, 1'b1);
      device_txn(1'b1, 11);
      begin
        wait_done();
        send(8'hFF, 1'b1, 1'b1);
      end
    join
    device_txn(1'b1, 11);

    // NACK: device leaves DATA high on the 11th edge.
    @(negedge clk);
    fork
      send(8'hAA, 1'b1, 1'b0);
      device_txn(1'b0, 11);
    join
    repeat (HALF) @(negedge clk);
    chk_eq("nack_clk_pin", ps2_clk, 1);
    chk_eq("nack_data_pin", ps2_data, 1);
    chk_eq("nack_busy", bus.busy, 0);

    // A second request during BITS must not disturb 0xF4.
    @(negedge clk);
    fork
      send(8'hF4, 1'b1, 1'b1);
      device_txn(1'b1, 11);
      begin
        repeat (INHIBIT + 100) @(negedge clk);
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk_eq("no_phantom_busy", bus.busy, 0);

    // Reset after the 5th device edge while the host pulls DATA low for d4=0.
    fork
      send(8'h2C, 1'b0, 1'b0);
      device_txn(1'b1, 5);
    join
    repeat (3) @(negedge clk);
    chk_eq("pre_rst_data_low", ps2_data, 0);
    d0  = done_cnt;
    e0  = err_cnt;
    rst = 1'b1;
    #1;
    chk_eq("rst_mid_data_pin", ps2_data, 1);
    chk_eq("rst_mid_clk_pin", ps2_clk, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_eq("rst_mid_no_done", done_cnt - d0, 0);
    chk_eq("rst_mid_no_err", err_cnt - e0, 0);
    chk_eq("rst_mid_busy", bus.busy, 0);

    // Fresh frame after reset.
    fork
      send(8'h01, 1'b1, 1'b1);
      device_txn(1'b1, 11);
    join

    // Timeout: device never clocks.
    @(negedge clk);
    send(8'h42, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < INHIBIT + TIMEOUT + 100; i++) begin
      @(negedge clk);
      if (bus.err) begin
        seen = 1'b1;
        break;
      end
    end
    chk_eq("timeout_seen", seen, 1);
    @(negedge clk);
    chk_eq("timeout_latency", err_cyc - start_cyc, TIMEOUT);
    chk_eq("timeout_clk_pin", ps2_clk, 1);
    chk_eq("timeout_data_pin", ps2_data, 1);
    chk_eq("timeout_busy", bus.busy, 0);

    repeat (5) @(negedge clk);
    chk_eq("total_done", done_cnt, 4);
    chk_eq("total_err", err_cnt, 2);
    chk_eq("done_err_overlap", both_cnt, 0);
    chk_eq("busy_at_done", busy_at_done, 0);
    chk_eq("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_time_limit: got expired expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 12000, sets clk cycles PS2_CLK is held low before the start bit (120 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, sets the watchdog limit in clk cycles between device clock edges (20 ms).
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 tx_data  input  8  command byte to send to the device.
REQ-006 tx_start  input  1  one-cycle request; accepted only while busy=0.
REQ-007 busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-008 done  output  1  one-cycle pulse on successful ACK completion.
REQ-009 err  output  1  one-cycle pulse on NACK or timeout.
REQ-010 PS2_CLK  inout  1  open-drain; driven 0 or Z only.
REQ-011 PS2_DATA  inout  1  open-drain; driven 0 or Z only.

Function
REQ-012 Line drive SHALL come from two registered enables (clk_low, data_low); a pin is 0 when its enable is 1, else Z.
REQ-013 PS2_CLK and PS2_DATA SHALL each be sampled through a 2-FF synchronizer; a falling edge is previous synced=1, current synced=0.
REQ-014 States SHALL be IDLE, INHIBIT, START, BITS, ACK_WAIT, ACK_RELEASE.
REQ-015 IDLE: both lines released; tx_start=1 latches frame = {1 (stop), ~^tx_data (odd parity), tx_data}, loads shift register, enters INHIBIT next cycle.
REQ-016 tx_start while busy=1 SHALL be ignored, with no effect on the frame in flight.
REQ-017 INHIBIT: clk_low=1 for exactly INHIBIT_CYCLES cycles, data_low=0; then enter START.
REQ-018 START: clk_low=0, data_low=1 (start bit); watchdog cleared; enter BITS.
REQ-019 BITS: on each device falling edge, drive the next frame bit LSB-first (data_low = ~bit): edges 1-8 carry d0-d7, edge 9 parity, edge 10 stop (release).
REQ-020 After the 10th falling edge, enter ACK_WAIT with data_low=0.
REQ-021 ACK_WAIT: on the 11th falling edge, synced PS2_DATA=0 enters ACK_RELEASE; =1 is a NACK and produces err.
REQ-022 ACK_RELEASE: wait until synced PS2_CLK=1 and PS2_DATA=1, then return to IDLE with done=1 for that one cycle.
REQ-023 The watchdog SHALL count cycles in START/BITS/ACK_WAIT/ACK_RELEASE and clear on each falling edge.
REQ-024 When the watchdog reaches TIMEOUT_CYCLES, the block SHALL release both lines, pulse err, and return to IDLE.
REQ-025 busy=0 and done/err pulse SHALL coincide with the first IDLE cycle; a tx_start in that cycle SHALL be accepted.
REQ-026 done and err SHALL never assert in the same cycle.
REQ-027 The bit counter SHALL be 4 bits wide and the watchdog/inhibit counter 21 bits wide; no wrap-around is permitted within a frame.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, clk_low=0, data_low=0, busy=0, done=0, err=0, counters=0, shift register=0.
REQ-029 Reset mid-frame SHALL release both lines immediately, with no done or err pulse.
REQ-030 After reset release, the first valid tx_start SHALL send a complete fresh frame.

Verification
REQ-031 Reset check: assert rst -> all outputs 0, both pins Z (pulled high), busy=0.
REQ-032 Send 0xED to a modeled keyboard that ACKs -> PS2_CLK low for exactly 12000 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop released; then a single done pulse and busy=0.
REQ-033 Send 0x01 -> parity bit 0; send 0xFF -> parity bit 1; device-sampled bytes match.
REQ-034 NACK: device leaves DATA high on the 11th edge -> err pulse, no done, lines released, IDLE.
REQ-035 Timeout: device never clocks after START -> err exactly TIMEOUT_CYCLES cycles after START, both lines Z.
REQ-036 Abuse: tx_start=0x55 during BITS of a 0xF4 frame -> 0xF4 delivered intact; rst mid-bit 5 -> pins Z the same cycle, no done/err.
